boid_frame_scheduler: RTL
=========================

Name: boid_frame_scheduler

Overview:
- Sequences the per-frame copy of all BPU positions into the resettable boid display RAM.
- On a qualified end-of-frame event it issues a one-cycle clear pulse to the display RAM, then walks a boid index from 0 to MAX_BOIDS-1.
- During the walk it drives the BPU read-select and the display-RAM write enable, stalling on any boid the CPU is writing in that same cycle.
- Sits between VGAController (frame end), the switch inputs, the CPU boid-write decode and Boid_display_mem. It replaces the ad-hoc refresh logic in the top level.

Parameters:
- MAX_BOIDS, 128, number of BPUs scanned per refresh.
- BITS_FOR_BOIDS, $clog2(MAX_BOIDS), width of the boid index.
- REFRESH_DIV_BITS, 4, slow mode refreshes once per 2^REFRESH_DIV_BITS qualified frame ends.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- frame_end  in  1  screenEnd_out level from VGAController, synchronous to clock; rising edge = frame end.
- mode_freeze  in  1  (SW[0]) 1 = no new refreshes start.
- mode_every_frame  in  1  (SW[1]) 1 = refresh every frame; 0 = divided refresh.
- cpu_wr_active  in  1  CPU is writing a boid this cycle.
- cpu_wr_index  in  BITS_FOR_BOIDS  index of the boid being written.
- boid_sel  out  BITS_FOR_BOIDS  BPU read select (feeds the one-hot decoder).
- disp_we  out  1  display-RAM write enable for the currently selected BPU address.
- disp_clear  out  1  one-cycle switch/clear pulse to the display RAM.
- busy  out  1  high from the clear cycle until the scan is done.
- scan_done  out  1  one-cycle pulse after the last boid is written.
- overrun_cnt  out  8  saturating count of triggers dropped because busy was high.

Behaviour:
- Reset (asynchronous):
  - State = IDLE.
  - boid_sel = 0, disp_we = 0, disp_clear = 0, busy = 0, scan_done = 0, overrun_cnt = 0.
  - Divider = 0, frame_end_q = 0.
- Edge detect: fe_rise = frame_end & ~frame_end_q, where frame_end_q is a 1-cycle register.
- Divider: increments on every fe_rise, wrapping at 2^REFRESH_DIV_BITS.
- Qualified trigger: trig = fe_rise & ~mode_freeze & (mode_every_frame | divider == all-ones, evaluated before the increment).
- State IDLE:
  - Outputs low, boid_sel = 0.
  - trig -> CLEAR.
- State CLEAR:
  - disp_clear = 1 and busy = 1 for exactly one cycle.
  - Then -> SCAN with boid_sel = 0.
- State SCAN:
  - busy = 1.
  - stall = cpu_wr_active & (cpu_wr_index == boid_sel).
  - No stall: disp_we = 1 and boid_sel increments next cycle.
  - Stall: disp_we = 0 and boid_sel holds.
  - When disp_we = 1 with boid_sel == MAX_BOIDS-1 -> DONE.
- State DONE:
  - scan_done = 1 for one cycle, busy = 0.
  - Next cycle -> IDLE.
  - A trig arriving in the DONE cycle is accepted and goes directly to CLEAR.
- Latency: trig cycle -> disp_clear the next cycle. An unstalled scan takes MAX_BOIDS cycles, so trigger to scan_done = MAX_BOIDS + 2 cycles.
- Write timing: disp_we is combinationally aligned with boid_sel. The BPU address path is combinational, so the write lands in the same cycle.
- Busy and triggers:
  - A trig while in CLEAR or SCAN is dropped, and overrun_cnt increments (saturating at 255).
  - The divider still advances on every fe_rise regardless of state.
- Freeze: asserting mode_freeze mid-scan does not abort the scan. It only blocks new triggers.
- Mode change: changing mode_every_frame mid-scan has no effect until the next fe_rise.
- Reset mid-scan: immediate return to IDLE with outputs cleared. The display RAM is not cleared by this block.
- Continuous stall: the scheduler waits indefinitely. There is no timeout.

Optional Feature:
- Macro: BOID_SCHED_OVERRUN_CNT_EN.
- Defined: overrun_cnt behaves as described above.
- Undefined: overrun_cnt is tied to 0 and its counter logic is omitted. Dropped triggers still have no other side effect.

Decomposition:
- Shared package boid_pkg:
  - Constants MAX_BOIDS, BITS_FOR_BOIDS, VIDEO_WIDTH, VIDEO_HEIGHT, PIXEL_ADDRESS_WIDTH.
  - Scheduler state enum (IDLE, CLEAR, SCAN, DONE).
- One sub-module, frame_trigger_qualifier: edge detect, divider and mode gating, outputting trig.
- The FSM and index counter stay in boid_frame_scheduler.

Test Plan:
- Every-frame mode: mode_every_frame=1, one frame_end rise:
  - disp_clear is high exactly 1 cycle.
  - disp_we is high for 128 consecutive cycles with boid_sel 0..127.
  - scan_done pulses at cycle 130 after the trigger.
- Divided mode: mode_every_frame=0, 32 frame_end rises spaced 2000 cycles apart -> exactly 2 scans, started on rise 16 and rise 32.
- Freeze: mode_freeze=1 and 5 rises -> no disp_clear, busy stays 0, overrun_cnt stays 0.
- Stall: cpu_wr_active=1 with cpu_wr_index=10, held 3 cycles when boid_sel reaches 10:
  - boid_sel holds at 10 and disp_we=0 for 3 cycles.
  - Scan completes with 128 writes total.
  - Trigger to scan_done = 133 cycles.
- Overrun: a second frame_end rise 50 cycles into a scan -> overrun_cnt=1, no restart, a single scan_done.
- Reset: reset asserted at boid_sel=64 -> all outputs 0 asynchronously. The next trigger restarts the scan from boid_sel=0.

Source files
------------

// File: rtl/boid_pkg.sv
// Shared constants and scheduler state encoding for the boid display pipeline.
package boid_pkg;
  localparam int MAX_BOIDS           = 128;
  localparam int BITS_FOR_BOIDS      = $clog2(MAX_BOIDS);
  localparam int VIDEO_WIDTH         = 640;
  localparam int VIDEO_HEIGHT        = 480;
  localparam int PIXEL_ADDRESS_WIDTH = $clog2(VIDEO_WIDTH * VIDEO_HEIGHT);
  localparam int REFRESH_DIV_BITS    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } sched_state_t;
endpackage

// File: rtl/frame_trigger_qualifier.sv
// Turns the VGA end-of-frame level into a one-cycle refresh trigger,
// gated by the freeze switch and the every-frame / divided refresh mode.
module frame_trigger_qualifier #(
  parameter int DIV_BITS = boid_pkg::REFRESH_DIV_BITS
) (
  input  logic clock,
  input  logic reset,
  input  logic frame_end,
  input  logic mode_freeze,
  input  logic mode_every_frame,
  output logic trig
);
  logic                frame_end_q;
  logic [DIV_BITS-1:0] divider;
  logic                fe_rise;

  assign fe_rise = frame_end & ~frame_end_q;

  // The divider runs on every frame end, even when frozen or busy, so the
  // divided refresh cadence stays locked to the frame count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_end_q <= 1'b0;
      divider     <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking would let divider see the updated frame_end_q.
      frame_end_q <= frame_end;
      if (fe_rise) divider <= divider + DIV_BITS'(1);
    end
  end

  assign trig = fe_rise & ~mode_freeze & (mode_every_frame | (&divider));
endmodule

// File: rtl/boid_frame_scheduler.sv
// Per-frame copy sequencer from the BPUs into the boid display RAM: clear pulse,
// then an index walk that stalls on CPU writes. Optional: BOID_SCHED_OVERRUN_CNT_EN.
module boid_frame_scheduler #(
  parameter int MAX_BOIDS        = boid_pkg::MAX_BOIDS,
  parameter int BITS_FOR_BOIDS   = $clog2(MAX_BOIDS),
  parameter int REFRESH_DIV_BITS = boid_pkg::REFRESH_DIV_BITS
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      frame_end,
  input  logic                      mode_freeze,
  input  logic                      mode_every_frame,
  input  logic                      cpu_wr_active,
  input  logic [BITS_FOR_BOIDS-1:0] cpu_wr_index,
  output logic [BITS_FOR_BOIDS-1:0] boid_sel,
  output logic                      disp_we,
  output logic                      disp_clear,
  output logic                      busy,
  output logic                      scan_done,
  output logic [7:0]                overrun_cnt
);
  import boid_pkg::*;

  localparam logic [BITS_FOR_BOIDS-1:0] LAST_IDX = BITS_FOR_BOIDS'(MAX_BOIDS - 1);

  sched_state_t              state, state_nxt;
  logic [BITS_FOR_BOIDS-1:0] boid_sel_nxt;
  logic                      trig;
  logic                      stall;

  frame_trigger_qualifier #(
    .DIV_BITS(REFRESH_DIV_BITS)
  ) u_trigger (
    .clock            (clock),
    .reset            (reset),
    .frame_end        (frame_end),
    .mode_freeze      (mode_freeze),
    .mode_every_frame (mode_every_frame),
    .trig             (trig)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      boid_sel <= '0;
    end else begin
      state    <= state_nxt;
      boid_sel <= boid_sel_nxt;
    end
  end

  // A CPU write to the boid under the read select wins; the scan retries it.
  assign stall = cpu_wr_active & (cpu_wr_index == boid_sel);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    boid_sel_nxt = boid_sel;
    disp_we      = 1'b0;
    disp_clear   = 1'b0;
    busy         = 1'b0;
    scan_done    = 1'b0;
    case (state)
      IDLE: begin
        boid_sel_nxt = '0;
        if (trig) state_nxt = CLEAR;
      end
      CLEAR: begin
        disp_clear   = 1'b1;
        busy         = 1'b1;
        boid_sel_nxt = '0;
        state_nxt    = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (!stall) begin
          disp_we = 1'b1;
          if (boid_sel == LAST_IDX) begin
            boid_sel_nxt = '0;
            state_nxt    = DONE;
          end else begin
            boid_sel_nxt = boid_sel + BITS_FOR_BOIDS'(1);
          end
        end
      end
      DONE: begin
        scan_done    = 1'b1;
        boid_sel_nxt = '0;
        state_nxt    = trig ? CLEAR : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BOID_SCHED_OVERRUN_CNT_EN
  logic [7:0] overrun_q;

  // DONE is not busy, so a trigger there is accepted rather than counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun_q <= 8'd0;
    end else if (trig && busy && (overrun_q != 8'hFF)) begin
      overrun_q <= overrun_q + 8'd1;
    end
  end

  assign overrun_cnt = overrun_q;
`else
  assign overrun_cnt = 8'd0;
`endif
endmodule
